// File: rtl/hc164_pkg.sv
// Shared types and constants for the 74HC164 digit scanner.
package hc164_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        SHOW      = 3'd4
    } scan_state_t;

    // Segment bit positions within a byte: 7 = dp, 6..0 = g,f,e,d,c,b,a.
    localparam int SEG_DP_BIT = 7;

    // Active-high segment patterns for nibbles 0..F (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hc164_digit_scanner_hex_to_7seg.sv
// Combinational nibble + decimal point to 7-segment byte decoder.
module hex_to_7seg
    import hc164_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    // Look up the segment pattern and merge in the decimal point.
    always_comb begin
        o_seg             = {1'b0, SEG_LUT[i_nibble]};
        o_seg[SEG_DP_BIT] = i_dp;
    end

endmodule

// File: rtl/hc164_digit_scanner.sv
// Multiplexed 7-segment scanner feeding a 74HC164 serial driver.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  IDLE      | not scanning; snapshot inputs and start when run=1
//  LOAD      | decode snapshot digit idx into drv_data
//  ISSUE     | request a shift while the driver is idle; leave once it
//            | has accepted (done falls after our shift)
//  WAIT_DONE | driver busy shifting; all digit lines blanked
//  SHOW      | light digit idx for DWELL cycles, then next digit/frame
module hc164_digit_scanner
    import hc164_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000
)
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  run,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            drv_data,
    output logic                  drv_shift,
    input  logic                  drv_done,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

    scan_state_t           r_state;
    logic [IW-1:0]         r_idx;
    logic [CW-1:0]         r_cnt;
    logic [7:0]            r_drv_data;
    logic                  r_frame_done;
    logic                  r_issued;
    logic [4*DIGITS-1:0]   r_snap_digits;
    logic [DIGITS-1:0]     r_snap_dp;

    logic [3:0]            w_nibble;
    logic                  w_dp;
    logic [7:0]            w_seg;

    assign w_nibble = r_snap_digits[{r_idx, 2'b00} +: 4];
    assign w_dp     = r_snap_dp[r_idx];

    hex_to_7seg u_dec (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_seg)
    );

    // Scan sequencer: snapshot, decode, hand off to driver, dwell, advance.
    // r_issued separates "done low because our shift was accepted" from
    // "done already low on entry", so a busy driver never gets skipped.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_drv_data    <= '0;
            r_frame_done  <= 1'b0;
            r_issued      <= 1'b0;
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_snap_digits <= digits;
                        r_snap_dp     <= dp;
                        r_idx         <= '0;
                        r_state       <= LOAD;
                    end
                end
                LOAD: begin
                    r_drv_data <= w_seg;
                    r_issued   <= 1'b0;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    if (drv_done) begin
                        r_issued <= 1'b1;
                    end else if (r_issued) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (drv_done) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (r_cnt == '0) begin
                        if (r_idx == IDX_LAST) begin
                            r_idx        <= '0;
                            r_frame_done <= 1'b1;
                            if (run) begin
                                r_snap_digits <= digits;
                                r_snap_dp     <= dp;
                                r_state       <= LOAD;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Digit lines decode straight from state so reset blanks them at once.
    always_comb begin
        digit_sel = '0;
        if (r_state == SHOW) begin
            digit_sel[r_idx] = 1'b1;
        end
    end

    assign drv_shift  = (r_state == ISSUE) && drv_done;
    assign drv_data   = r_drv_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hc164_digit_scanner.sv
// Bench for hc164_digit_scanner with a behavioural 74HC164 driver model.
module tb_hc164_digit_scanner;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;

    logic        clk;
    logic        nrst;
    logic        run;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [7:0]  drv_data;
    logic        drv_shift;
    logic        drv_done;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int errs;
    int checks;
    int frames_exp;
    int fd_count;

    logic [7:0] exp_q[$];
    logic [3:0] sel_q[$];

    // driver model: accepts a byte on shift, 8 bit cycles MSB first plus a latch cycle
    logic       force_busy;
    logic       drv_busy;
    logic [3:0] drv_cnt;
    logic [7:0] drv_sr;
    logic       sda;
    logic       sda_vld;

    assign drv_done = ~drv_busy & ~force_busy;

    hc164_digit_scanner #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .run        (run),
        .digits     (digits),
        .dp         (dp),
        .drv_data   (drv_data),
        .drv_shift  (drv_shift),
        .drv_done   (drv_done),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drv_busy <= 1'b0;
            drv_cnt  <= '0;
            drv_sr   <= '0;
            sda      <= 1'b0;
            sda_vld  <= 1'b0;
        end else begin
            sda_vld <= 1'b0;
            if (!drv_busy) begin
                if (drv_shift) begin
                    drv_busy <= 1'b1;
                    drv_sr   <= drv_data;
                    drv_cnt  <= 4'd9;
                end
            end else begin
                if (drv_cnt > 4'd1) begin
                    sda     <= drv_sr[7];
                    sda_vld <= 1'b1;
                    drv_sr  <= {drv_sr[6:0], 1'b0};
                end
                drv_cnt <= drv_cnt - 4'd1;
                if (drv_cnt == 4'd1) drv_busy <= 1'b0;
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // byte scoreboard: drv_data at handoff and the serial stream both against the queue
    logic [7:0] shifted_byte;
    logic [7:0] sda_acc;
    int         nbits;
    always @(negedge clk) begin
        if (!nrst) begin
            nbits = 0;
        end else begin
            if (drv_shift && drv_done) shifted_byte = drv_data;
            if (sda_vld) begin
                sda_acc = {sda_acc[6:0], sda};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        check("byte_unexpected", 32'(sda_acc), 32'h1FF);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("drv_data", 32'(shifted_byte), 32'(e));
                        check("sda_msb_first", 32'(sda_acc), 32'(e));
                    end
                end
            end
        end
    end

    // digit_sel scoreboard: order of digits and dwell length
    logic [3:0] prev_sel;
    int         run_len;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_sel = '0;
            run_len  = 0;
        end else begin
            if (digit_sel != prev_sel) begin
                if (prev_sel != '0) check("dwell_len", 32'(run_len), 32'(DWELL));
                if (digit_sel != '0) begin
                    if (sel_q.size() == 0) check("sel_unexpected", 32'(digit_sel), 32'h0);
                    else check("digit_sel", 32'(digit_sel), 32'(sel_q.pop_front()));
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sel = digit_sel;
        end
    end

    // frame_done must be single-cycle pulses
    logic prev_fd;
    always @(negedge clk) begin
        if (!nrst) begin
            prev_fd = 1'b0;
        end else begin
            if (frame_done) begin
                fd_count++;
                if (prev_fd) check("frame_done_width", 32'd2, 32'd1);
            end
            prev_fd = frame_done;
        end
    end

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic push_frame(logic [3:0][7:0] bytes);
        for (int i = 0; i < DIGITS; i++) begin
            exp_q.push_back(bytes[i]);
            sel_q.push_back(4'(1 << i));
        end
    endtask

    task automatic wait_sel(logic [3:0] val, string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (digit_sel == val) return;
        end
        checks++;
        errs++;
        $display("FAIL %s: timeout waiting for digit_sel=%0h, got %0h", name, val, digit_sel);
    endtask

    task automatic wait_fd(string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        checks++;
        errs++;
        $display("FAIL %s: timeout waiting for frame_done", name);
    endtask

    task automatic idle_check(string name);
        logic any_s;
        logic any_sel;
        any_s   = 1'b0;
        any_sel = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (drv_shift) any_s = 1'b1;
            if (digit_sel != '0) any_sel = 1'b1;
        end
        check({name, "_idle_shift"}, 32'(any_s), 32'd0);
        check({name, "_idle_sel"}, 32'(any_sel), 32'd0);
    endtask

    initial begin
        errs       = 0;
        checks     = 0;
        frames_exp = 0;
        fd_count   = 0;
        nrst       = 1'b0;
        run        = 1'b0;
        digits     = '0;
        dp         = '0;
        force_busy = 1'b0;

        vecs[0] = '{16'h4321, 4'b0000, {8'h66, 8'h4F, 8'h5B, 8'h06}};
        vecs[1] = '{16'hF8A0, 4'b0010, {8'h71, 8'h7F, 8'hF7, 8'h3F}};
        vecs[2] = '{16'hBCDE, 4'b1001, {8'hFC, 8'h39, 8'h5E, 8'hF9}};
        vecs[3] = '{16'h5678, 4'b0100, {8'h6D, 8'hFD, 8'h07, 8'h7F}};
        vecs[4] = '{16'h9999, 4'b1111, {8'hEF, 8'hEF, 8'hEF, 8'hEF}};

        repeat (3) @(negedge clk);
        check("rst_digit_sel", 32'(digit_sel), 32'h0);
        check("rst_drv_shift", 32'(drv_shift), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_drv_data", 32'(drv_data), 32'h0);
        nrst = 1'b1;
        idle_check("run_low");

        // one frame per vector; run drops during digit 0 so each frame still completes
        for (int v = 0; v < 5; v++) begin
            digits = vecs[v].digits;
            dp     = vecs[v].dp;
            push_frame(vecs[v].exp);
            frames_exp++;
            run = 1'b1;
            wait_sel(4'b0001, "vec_start");
            run = 1'b0;
            wait_fd("vec_frame");
            idle_check("vec");
        end

        // inputs change mid-frame: current frame unaffected, next frame resnapshots
        digits = 16'h4321;
        dp     = 4'b0000;
        push_frame(vecs[0].exp);
        run = 1'b1;
        wait_sel(4'b0010, "mid_d1");
        digits = 16'h0000;
        push_frame({8'h3F, 8'h3F, 8'h3F, 8'h3F});
        frames_exp += 2;
        wait_fd("mid_frame1");
        wait_sel(4'b0010, "mid_f2_d1");
        run = 1'b0;
        wait_fd("mid_frame2");
        idle_check("run_drop");

        // driver held busy while in ISSUE: no shift, no digit lit, then resume
        digits = 16'h4321;
        push_frame(vecs[0].exp);
        frames_exp++;
        run = 1'b1;
        wait_sel(4'b0001, "hold_d0");
        wait_sel(4'b0000, "hold_load");
        force_busy = 1'b1;
        begin
            logic any_s;
            logic any_sel;
            any_s   = 1'b0;
            any_sel = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (drv_shift) any_s = 1'b1;
                if (digit_sel != '0) any_sel = 1'b1;
            end
            check("hold_shift", 32'(any_s), 32'd0);
            check("hold_sel", 32'(any_sel), 32'd0);
        end
        force_busy = 1'b0;
        run = 1'b0;
        wait_fd("hold_frame");
        idle_check("hold");

        // reset during WAIT_DONE of digit 1
        digits = 16'h4321;
        push_frame(vecs[0].exp);
        run = 1'b1;
        wait_sel(4'b0001, "rst_d0");
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clk);
                if (drv_shift && drv_done) seen = 1'b1;
            end
            check("rst_shift_seen", 32'(seen), 32'd1);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        exp_q.delete();
        sel_q.delete();
        #1;
        check("wd_rst_digit_sel", 32'(digit_sel), 32'h0);
        check("wd_rst_drv_shift", 32'(drv_shift), 32'h0);
        check("wd_rst_frame_done", 32'(frame_done), 32'h0);
        check("wd_rst_drv_data", 32'(drv_data), 32'h0);
        digits = vecs[3].digits;
        dp     = vecs[3].dp;
        @(negedge clk);
        nrst = 1'b1;
        push_frame(vecs[3].exp);
        frames_exp++;
        wait_sel(4'b0001, "rst_restart");
        run = 1'b0;
        wait_fd("rst_frame");
        idle_check("rst");

        // reset while a digit is lit blanks it without waiting for a clock
        digits = 16'h4321;
        dp     = 4'b0000;
        push_frame(vecs[0].exp);
        run = 1'b1;
        wait_sel(4'b0001, "show_rst_d0");
        @(negedge clk);
        nrst = 1'b0;
        exp_q.delete();
        sel_q.delete();
        #1;
        check("show_rst_digit_sel", 32'(digit_sel), 32'h0);
        run = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        idle_check("show_rst");

        check("bytes_left", 32'(exp_q.size()), 32'd0);
        check("sels_left", 32'(sel_q.size()), 32'd0);
        check("frame_count", 32'(fd_count), 32'(frames_exp));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hc164_digit_scanner.md
Name: hc164_digit_scanner

Overview:
- Upstream sequencer for the 74HC164 serial driver in a multiplexed 7-segment display.
- Snapshots a frame of DIGITS hex nibbles plus decimal points, and decodes each digit to an 8-bit segment byte.
- Hands each byte to the driver over its data/shift/done handshake, then lights that digit's common line for DWELL cycles.
- Blanks all digit lines while shifting, which prevents ghosting.

Parameters:
- DIGITS, 4, number of multiplexed digits; legal range 2..16.
- DWELL, 1000, clk cycles each digit is lit; minimum 1.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- run  input  1  level; scanning continues while high; sampled only at frame boundaries.
- digits  input  4*DIGITS  hex value per digit; digit i occupies bits [4i+3:4i].
- dp  input  DIGITS  decimal point per digit; bit i belongs to digit i.
- drv_data  output  8  segment byte to the driver: bit7=dp, bits6..0 = g,f,e,d,c,b,a; 1 = segment on.
- drv_shift  output  1  load request to the driver.
- drv_done  input  1  driver idle flag; high = idle.
- digit_sel  output  DIGITS  one-hot, active-high digit enable.
- frame_done  output  1  one-cycle pulse after the last digit's dwell.

Behaviour:
- Reset values: state IDLE, idx=0, dwell counter=0, drv_data=0, digit_sel=0, frame_done=0, snapshot registers=0. drv_shift=0 during reset.
- Reset mid-operation aborts immediately. digit_sel drops to 0 asynchronously.
- States: IDLE, LOAD, ISSUE, WAIT_DONE, SHOW.
- IDLE: when run=1, next state is LOAD with idx=0. The same edge copies digits and dp into the snapshot.
- LOAD (1 cycle): drv_data <= decode(snap_digit[idx], snap_dp[idx]). Next state is ISSUE.
- ISSUE:
  - drv_shift = (state==ISSUE) && drv_done. This is a Mealy output, so shift falls in the same cycle that done falls.
  - Stay in ISSUE while drv_done=1.
  - On drv_done=0, go to WAIT_DONE.
  - If drv_done is already 0 on entry, drv_shift stays 0 until done returns high.
- WAIT_DONE: on drv_done=1, go to SHOW and load the dwell counter with DWELL-1.
- SHOW:
  - digit_sel = one-hot(idx).
  - The counter decrements each cycle. When it reaches 0, the state exits.
  - Exit to LOAD with idx+1 when idx<DIGITS-1.
  - When idx=DIGITS-1, idx wraps to 0 and frame_done is registered high for the following cycle.
  - After the last digit, go to LOAD if run=1 (re-snapshot on this edge), else go to IDLE.
- digit_sel is 0 in every state other than SHOW. drv_data holds its value outside LOAD.
- run deasserted mid-frame: the current frame completes, including the last dwell. Scanning then stops at the boundary.
- Decode table for nibbles 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. dp ORs 0x80.
- Counter widths: idx is $clog2(DIGITS) bits; the dwell counter is max(1,$clog2(DWELL)) bits.
- Per-digit latency with the driver's en tied high: LOAD 1 + ISSUE 1 + driver 9 + DWELL.

Decomposition:
- Package hc164_pkg:
  - State enum scan_state_t.
  - The 16-entry SEG_LUT constant.
  - SEG_DP_BIT = 7.
- Sub-module hex_to_7seg: combinational nibble+dp to byte, built on SEG_LUT. It is instantiated once, indexed by idx.

Test Plan:
- Setup for all scenarios: DIGITS=4, DWELL=4, paired with the real driver (en=1).
- Reset then run=1, digits=16'h4321, dp=0:
  - Bytes shifted in order 06, 5B, 4F, 66.
  - Each byte appears MSB-first on sda.
  - digit_sel shows 0001, 0010, 0100, 1000, each for exactly 4 cycles.
  - frame_done pulses once.
- digits=16'hF8A0, dp=4'b0010: bytes 3F, F7, 7F, 71.
- digits changed to 16'h0000 mid-frame: the remaining bytes of the current frame are unchanged; the next frame shifts 3F four times.
- Hold drv_done=0 externally for 20 cycles while in ISSUE:
  - drv_shift stays 0.
  - digit_sel stays 0.
  - Shifting resumes once drv_done=1.
- run dropped during digit 1's SHOW:
  - Digits 2 and 3 are still shown.
  - frame_done pulses.
  - The state reaches IDLE and digit_sel=0.
- nrst asserted during WAIT_DONE:
  - digit_sel=0, drv_shift=0, frame_done=0 immediately.
  - After release, with run=1, the scan restarts at digit 0 with a fresh snapshot.
